// File: rtl/dekatron_pkg.sv
// Shared definitions for the dekatron step counter.
//   DEKATRON_WIDTH / DEKATRON_MAX : BCD digit width and largest digit value
//   dek_op_t                      : command codes accepted on Op
//   dek_state_t                   : control FSM states
//   dek_clamp()                   : saturates a BCD digit code to 9
package dekatron_pkg;

    localparam int DEKATRON_WIDTH = 4;
    localparam logic [DEKATRON_WIDTH-1:0] DEKATRON_MAX = 4'd9;

    typedef enum logic [2:0] {
        OP_INC  = 3'd0,
        OP_DEC  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_SET  = 3'd4,
        OP_ZERO = 3'd5
    } dek_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_LOAD,
        ST_SETTLE
    } dek_state_t;

    function automatic logic [DEKATRON_WIDTH-1:0] dek_clamp(input logic [DEKATRON_WIDTH-1:0] d);
        return (d > DEKATRON_MAX) ? DEKATRON_MAX : d;
    endfunction

endpackage

// File: rtl/dekatron_digit.sv
// One BCD digit of the dekatron counter.
//   clk, rst  : clock, synchronous active-high reset (digit -> 0)
//   step_up   : advance one position (9 wraps to 0)
//   step_dn   : retreat one position (0 wraps to 9)
//   load      : overrides stepping, digit <= load_val
//   digit     : current digit value
//   carry_up  : digit == 9 (an up step here ripples into the next digit)
//   carry_dn  : digit == 0 (a down step here ripples into the next digit)
module dekatron_digit
    import dekatron_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step_up,
    input  logic                      step_dn,
    input  logic                      load,
    input  logic [DEKATRON_WIDTH-1:0] load_val,
    output logic [DEKATRON_WIDTH-1:0] digit,
    output logic                      carry_up,
    output logic                      carry_dn
);

    logic [DEKATRON_WIDTH-1:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_val;
        end else if (step_up) begin
            digit_d = (digit_q == DEKATRON_MAX) ? '0 : digit_q + DEKATRON_WIDTH'(1);
        end else if (step_dn) begin
            digit_d = (digit_q == '0) ? DEKATRON_MAX : digit_q - DEKATRON_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit    = digit_q;
    assign carry_up = (digit_q == DEKATRON_MAX);
    assign carry_dn = (digit_q == '0);

endmodule

// File: rtl/dekatron_step_counter.sv
// D_NUM-digit BCD up/down counter with multi-step ADD/SUB bursts, load and
// clear, driven over a Request/Ready handshake.
//   Clk, Rst  : clock, synchronous active-high reset
//   Request   : command strobe, taken only while Ready=1 (dropped otherwise)
//   Op        : dek_op_t command; Count = burst length for ADD/SUB; In = BCD load value
//   Ready     : FSM idle
//   Zero, Top : Out == 0, Out == limit (combinational from the count register)
//   Wrap      : one-cycle pulse per wrapped unit step
//   Out       : BCD count
// Build option: define DEKATRON_SETTLE_EMU_EN to add PULSE_CYCLES-1 settle
// cycles after every step and every load (glow-transfer tube emulation).
module dekatron_step_counter
    import dekatron_pkg::*;
#(
    parameter int unsigned        D_NUM          = 3,
    parameter int unsigned        STEP_W         = 4,
    parameter bit                 TOP_LIMIT_MODE = 1'b0,
    parameter logic [D_NUM*4-1:0] TOP_VALUE      = {D_NUM{4'd5}},
    parameter int unsigned        PULSE_CYCLES   = 10
) (
    input  logic                             Clk,
    input  logic                             Rst,
    input  logic                             Request,
    input  dek_op_t                          Op,
    input  logic [STEP_W-1:0]                Count,
    input  logic [D_NUM*DEKATRON_WIDTH-1:0]  In,
    output logic                             Ready,
    output logic                             Zero,
    output logic                             Top,
    output logic                             Wrap,
    output logic [D_NUM*DEKATRON_WIDTH-1:0]  Out
);

    localparam int unsigned VW = D_NUM * DEKATRON_WIDTH;
    localparam logic [VW-1:0] LIMIT = TOP_LIMIT_MODE ? TOP_VALUE : {D_NUM{DEKATRON_MAX}};

    dek_state_t        state_q, state_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              dir_up_q, dir_up_d;
    logic              zero_q, zero_d;
    logic [VW-1:0]     in_q, in_d;
    logic              wrap_q;

`ifdef DEKATRON_SETTLE_EMU_EN
    localparam int unsigned TMR_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((PULSE_CYCLES > 1) ? PULSE_CYCLES - 2 : 0);
    // With a single-cycle pulse there is nothing to wait for; SETTLE is skipped.
    localparam bit SETTLE_ON = (PULSE_CYCLES > 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`else
    // Settle timing is not built; PULSE_CYCLES is accepted and has no effect.
    if (PULSE_CYCLES < 1) begin : g_pulse_cycles_unused
    end
`endif

    logic [D_NUM-1:0] carry_up, carry_dn, chain_up, chain_dn;
    logic [VW-1:0]    digits, ld_val;
    logic             do_step, do_load, wrap_up, wrap_now, step_up_en, step_dn_en;

    assign do_step = (state_q == ST_STEP) && (rem_q != '0);
    assign do_load = (state_q == ST_LOAD);

    // Limit mode compares the packed BCD vector as unsigned, so a value loaded
    // above TOP_VALUE also wraps to 0 on the next up step.
    assign wrap_up    = TOP_LIMIT_MODE ? (digits >= TOP_VALUE) : (&carry_up);
    assign wrap_now   = do_step && (dir_up_q ? wrap_up : (&carry_dn));
    assign step_up_en = do_step && dir_up_q && !wrap_now;
    assign step_dn_en = do_step && !dir_up_q && !wrap_now;

    // A wrap is carried out as a parallel load of 0 (up) or the limit (down),
    // which covers both the full-range and the limited-range rule.
    for (genvar k = 0; k < D_NUM; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign chain_up[k] = 1'b1;
            assign chain_dn[k] = 1'b1;
        end else begin : g_upper
            assign chain_up[k] = chain_up[k-1] & carry_up[k-1];
            assign chain_dn[k] = chain_dn[k-1] & carry_dn[k-1];
        end

        assign ld_val[k*DEKATRON_WIDTH +: DEKATRON_WIDTH] =
            do_load ? (zero_q ? '0 : dek_clamp(in_q[k*DEKATRON_WIDTH +: DEKATRON_WIDTH]))
                    : (dir_up_q ? '0 : LIMIT[k*DEKATRON_WIDTH +: DEKATRON_WIDTH]);

        dekatron_digit u_digit (
            .clk      (Clk),
            .rst      (Rst),
            .step_up  (step_up_en & chain_up[k]),
            .step_dn  (step_dn_en & chain_dn[k]),
            .load     (do_load | wrap_now),
            .load_val (ld_val[k*DEKATRON_WIDTH +: DEKATRON_WIDTH]),
            .digit    (digits[k*DEKATRON_WIDTH +: DEKATRON_WIDTH]),
            .carry_up (carry_up[k]),
            .carry_dn (carry_dn[k])
        );
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dir_up_d = dir_up_q;
        zero_d   = zero_q;
        in_d     = in_q;
`ifdef DEKATRON_SETTLE_EMU_EN
        timer_d  = timer_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Request) begin
                    in_d     = In;
                    rem_d    = '0;
                    zero_d   = (Op == OP_ZERO);
                    dir_up_d = (Op == OP_INC) || (Op == OP_ADD);
                    state_d  = ST_STEP;
                    case (Op)
                        OP_INC, OP_DEC:  rem_d = STEP_W'(1);
                        OP_ADD, OP_SUB:  rem_d = Count;
                        OP_SET, OP_ZERO: state_d = ST_LOAD;
                        default: ;  // undefined codes run as an empty burst
                    endcase
                end
            end
            ST_STEP: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_q - STEP_W'(1);
`ifdef DEKATRON_SETTLE_EMU_EN
                    if (SETTLE_ON) begin
                        state_d = ST_SETTLE;
                        timer_d = '0;
                    end else if (rem_d == '0) begin
                        state_d = ST_IDLE;
                    end
`else
                    if (rem_d == '0) begin
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            ST_LOAD: begin
`ifdef DEKATRON_SETTLE_EMU_EN
                if (SETTLE_ON) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef DEKATRON_SETTLE_EMU_EN
            ST_SETTLE: begin
                // rem is cleared when a load is accepted, so a load always exits to IDLE.
                if (timer_q == TMR_LAST) begin
                    state_d = (rem_q != '0) ? ST_STEP : ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
`ifdef DEKATRON_SETTLE_EMU_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_now;
`ifdef DEKATRON_SETTLE_EMU_EN
            timer_q <= timer_d;
`endif
        end
    end

    // Command operands: only meaningful after an accept, so no reset needed.
    always_ff @(posedge Clk) begin
        dir_up_q <= dir_up_d;
        zero_q   <= zero_d;
        in_q     <= in_d;
    end

    assign Ready = (state_q == ST_IDLE);
    assign Zero  = &carry_dn;
    assign Top   = (digits == LIMIT);
    assign Wrap  = wrap_q;
    assign Out   = digits;

endmodule

// File: tb/tb_dekatron_step_counter.sv
// Directed bench for dekatron_step_counter: one full-range instance and one
// limited-range instance (TOP=555) sharing clock, reset and command inputs;
// sel routes Request to one of them and selects whose outputs are observed.
module tb_dekatron_step_counter;
    import dekatron_pkg::*;

`ifdef DEKATRON_SETTLE_EMU_EN
    localparam int P = 10;
`else
    localparam int P = 1;
`endif
    localparam int LAT_MAX = 400;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        req;
    logic        sel;
    dek_op_t     Op;
    logic [3:0]  Count;
    logic [11:0] In;

    logic        ready_f, zero_f, top_f, wrap_f, ready_l, zero_l, top_l, wrap_l;
    logic [11:0] out_f, out_l;
    logic        ready, zero, top, wrap;
    logic [11:0] out, top_val;

    always #5 Clk = ~Clk;

    dekatron_step_counter #(.D_NUM(3), .STEP_W(4), .TOP_LIMIT_MODE(1'b0), .TOP_VALUE(12'h555), .PULSE_CYCLES(10)) u_full (
        .Clk(Clk), .Rst(Rst), .Request(req & ~sel), .Op(Op), .Count(Count), .In(In),
        .Ready(ready_f), .Zero(zero_f), .Top(top_f), .Wrap(wrap_f), .Out(out_f));

    dekatron_step_counter #(.D_NUM(3), .STEP_W(4), .TOP_LIMIT_MODE(1'b1), .TOP_VALUE(12'h555), .PULSE_CYCLES(10)) u_lim (
        .Clk(Clk), .Rst(Rst), .Request(req & sel), .Op(Op), .Count(Count), .In(In),
        .Ready(ready_l), .Zero(zero_l), .Top(top_l), .Wrap(wrap_l), .Out(out_l));

    assign ready   = sel ? ready_l : ready_f;
    assign zero    = sel ? zero_l  : zero_f;
    assign top     = sel ? top_l   : top_f;
    assign wrap    = sel ? wrap_l  : wrap_f;
    assign out     = sel ? out_l   : out_f;
    assign top_val = sel ? 12'h555 : 12'h999;

    int errors = 0;
    int checks = 0;
    int wraps;
    int topbad;
    int lat;
    logic [11:0] seq[$];

    // Present a command at a negedge; it is accepted at the following posedge.
    task automatic issue(input dek_op_t op, input logic [3:0] cnt, input logic [11:0] val);
        @(negedge Clk);
        Op = op; Count = cnt; In = val; req = 1'b1;
        @(posedge Clk);
    endtask

    // Returns the index of the first edge after acceptance that samples Ready=1
    // (0 on timeout). Records Out changes, Wrap pulses and Top consistency.
    // inject>0 pulses an OP_ZERO request at that point of the burst.
    task automatic wait_ready(input int inject, output int l);
        logic [11:0] last;
        wraps = 0; topbad = 0; seq.delete(); last = out; l = 0;
        for (int c = 1; c <= LAT_MAX; c++) begin
            @(negedge Clk);
            if (c == inject) begin req = 1'b1; Op = OP_ZERO; end else req = 1'b0;
            if (c == 1) begin In = 12'h777; Count = 4'hF; end
            wraps += int'(wrap);
            if (top !== (out == top_val)) topbad++;
            if (out !== last) begin seq.push_back(out); last = out; end
            if (ready) begin l = c; break; end
        end
    endtask

    task automatic do_cmd(input dek_op_t op, input logic [3:0] cnt, input logic [11:0] val, output int l);
        issue(op, cnt, val);
        wait_ready(0, l);
    endtask

    task automatic test_reset();
        sel = 1'b0;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        checks++; if (out_f !== 12'h000) begin errors++; $display("FAIL reset_out got=%h exp=000", out_f); end
        checks++; if (ready_f !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_f); end
        checks++; if (zero_f !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero_f); end
        checks++; if (wrap_f !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap_f); end
        checks++; if (top_f !== 1'b0) begin errors++; $display("FAIL reset_top got=%b exp=0", top_f); end
        checks++; if (out_l !== 12'h000) begin errors++; $display("FAIL reset_out_lim got=%h exp=000", out_l); end
    endtask

    task automatic test_inc();
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cmd(OP_INC, 4'd0, 12'h000, lat);
            checks++; if (lat !== 1 + P) begin errors++; $display("FAIL inc_latency[%0d] got=%0d exp=%0d", i, lat, 1 + P); end
        end
        checks++; if (out !== 12'h003) begin errors++; $display("FAIL inc_out got=%h exp=003", out); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL inc_zero got=%b exp=0", zero); end
    endtask

    task automatic test_set_clamp();
        sel = 1'b0;
        do_cmd(OP_SET, 4'd0, 12'h099, lat);
        checks++; if (lat !== 1 + P) begin errors++; $display("FAIL set_latency got=%0d exp=%0d", lat, 1 + P); end
        checks++; if (out !== 12'h099) begin errors++; $display("FAIL set_out got=%h exp=099", out); end
        checks++; if (wraps !== 0) begin errors++; $display("FAIL set_wrap got=%0d exp=0", wraps); end
        do_cmd(OP_INC, 4'd0, 12'h000, lat);
        checks++; if (out !== 12'h100) begin errors++; $display("FAIL ripple_out got=%h exp=100", out); end
        checks++; if (seq.size() != 1) begin errors++; $display("FAIL ripple_single_step got=%0d changes exp=1", seq.size()); end
        do_cmd(OP_SET, 4'd0, 12'h0A9, lat);
        checks++; if (out !== 12'h099) begin errors++; $display("FAIL clamp_out got=%h exp=099", out); end
    endtask

    task automatic test_full_wrap();
        sel = 1'b0;
        do_cmd(OP_ZERO, 4'd0, 12'h000, lat);
        checks++; if (lat !== 1 + P) begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", lat, 1 + P); end
        checks++; if (out !== 12'h000) begin errors++; $display("FAIL zero_out got=%h exp=000", out); end
        do_cmd(OP_DEC, 4'd0, 12'h000, lat);
        checks++; if (out !== 12'h999) begin errors++; $display("FAIL dec_wrap_out got=%h exp=999", out); end
        checks++; if (wraps !== 1) begin errors++; $display("FAIL dec_wrap_count got=%0d exp=1", wraps); end
        checks++; if (top !== 1'b1) begin errors++; $display("FAIL full_top got=%b exp=1", top); end
        @(negedge Clk);
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle got=%b exp=0", wrap); end
        do_cmd(OP_INC, 4'd0, 12'h000, lat);
        checks++; if (out !== 12'h000) begin errors++; $display("FAIL inc_wrap_out got=%h exp=000", out); end
        checks++; if (wraps !== 1) begin errors++; $display("FAIL inc_wrap_count got=%0d exp=1", wraps); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL inc_wrap_zero got=%b exp=1", zero); end
    endtask

    task automatic test_limit();
        sel = 1'b1;
        do_cmd(OP_SET, 4'd0, 12'h554, lat);
        do_cmd(OP_ADD, 4'd3, 12'h000, lat);
        checks++; if (lat !== 3 * P + 1) begin errors++; $display("FAIL lim_add_latency got=%0d exp=%0d", lat, 3 * P + 1); end
        checks++; if (seq.size() != 3 || seq[0] !== 12'h555 || seq[1] !== 12'h000 || seq[2] !== 12'h001) begin
            errors++; $display("FAIL lim_add_sequence got=%0d changes, last=%h exp=555,000,001", seq.size(), out);
        end
        checks++; if (wraps !== 1) begin errors++; $display("FAIL lim_add_wraps got=%0d exp=1", wraps); end
        checks++; if (topbad !== 0) begin errors++; $display("FAIL lim_top_tracking got=%0d bad cycles exp=0", topbad); end
        checks++; if (top !== 1'b0) begin errors++; $display("FAIL lim_top_after got=%b exp=0", top); end
        do_cmd(OP_ZERO, 4'd0, 12'h000, lat);
        do_cmd(OP_SUB, 4'd2, 12'h000, lat);
        checks++; if (lat !== 2 * P + 1) begin errors++; $display("FAIL lim_sub_latency got=%0d exp=%0d", lat, 2 * P + 1); end
        checks++; if (seq.size() != 2 || seq[0] !== 12'h555 || seq[1] !== 12'h554) begin
            errors++; $display("FAIL lim_sub_sequence got=%0d changes, last=%h exp=555,554", seq.size(), out);
        end
        checks++; if (wraps !== 1) begin errors++; $display("FAIL lim_sub_wraps got=%0d exp=1", wraps); end
        do_cmd(OP_SET, 4'd0, 12'h700, lat);
        checks++; if (out !== 12'h700) begin errors++; $display("FAIL lim_oor_hold got=%h exp=700", out); end
        do_cmd(OP_INC, 4'd0, 12'h000, lat);
        checks++; if (out !== 12'h000) begin errors++; $display("FAIL lim_oor_wrap_out got=%h exp=000", out); end
        checks++; if (wraps !== 1) begin errors++; $display("FAIL lim_oor_wraps got=%0d exp=1", wraps); end
    endtask

    task automatic test_add_zero_and_busy();
        sel = 1'b0;
        do_cmd(OP_SET, 4'd0, 12'h123, lat);
        do_cmd(OP_ADD, 4'd0, 12'h000, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add0_latency got=%0d exp=2", lat); end
        checks++; if (out !== 12'h123) begin errors++; $display("FAIL add0_out got=%h exp=123", out); end
        issue(OP_ADD, 4'd5, 12'h000);
        wait_ready(3, lat);
        checks++; if (lat !== 5 * P + 1) begin errors++; $display("FAIL busy_latency got=%0d exp=%0d", lat, 5 * P + 1); end
        checks++; if (out !== 12'h128) begin errors++; $display("FAIL busy_out got=%h exp=128", out); end
        repeat (3) @(negedge Clk);
        checks++; if (out !== 12'h128) begin errors++; $display("FAIL busy_not_queued got=%h exp=128", out); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_ready_after got=%b exp=1", ready); end
    endtask

    task automatic test_reset_midburst();
        sel = 1'b0;
        issue(OP_ADD, 4'd15, 12'h000);
        @(negedge Clk); req = 1'b0;
        @(negedge Clk);
        @(negedge Clk); Rst = 1'b1;
        @(negedge Clk); Rst = 1'b0;
        checks++; if (out !== 12'h000) begin errors++; $display("FAIL rst_mid_out got=%h exp=000", out); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", ready); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL rst_mid_wrap got=%b exp=0", wrap); end
        do_cmd(OP_INC, 4'd0, 12'h000, lat);
        checks++; if (lat !== 1 + P) begin errors++; $display("FAIL rst_mid_inc_latency got=%0d exp=%0d", lat, 1 + P); end
        checks++; if (out !== 12'h001) begin errors++; $display("FAIL rst_mid_inc_out got=%h exp=001", out); end
    endtask

    initial begin
        req = 1'b0; sel = 1'b0; Rst = 1'b1;
        Op = OP_INC; Count = 4'd0; In = 12'h000;
        test_reset();
        test_inc();
        test_set_clamp();
        test_full_wrap();
        test_limit();
        test_add_zero_and_busy();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
